// File: rtl/io_activity_conditioner_if.sv
// Pad-side signal bundle for io_activity_conditioner: raw pushbuttons and monitored
// lines in, debounced levels/events and stretched LED indicators out.
interface io_activity_conditioner_if #(
  parameter int unsigned N_BTN = 4,
  parameter int unsigned N_ACT = 2
);
  logic [N_BTN-1:0] btn_raw_i;
  logic [N_BTN-1:0] btn_o;
  logic [N_BTN-1:0] btn_press_o;
  logic [N_BTN-1:0] btn_release_o;
  logic [N_ACT-1:0] act_i;
  logic [N_ACT-1:0] led_o;

  modport master (
    output btn_raw_i,
    output act_i,
    input  btn_o,
    input  btn_press_o,
    input  btn_release_o,
    input  led_o
  );

  modport slave (
    input  btn_raw_i,
    input  act_i,
    output btn_o,
    output btn_press_o,
    output btn_release_o,
    output led_o
  );
endinterface

// File: rtl/io_activity_conditioner.sv
// Board I/O conditioning: debounces active-low pushbuttons into levels plus press/release
// pulses, and stretches UART line transitions into visible LED activity indicators.
module io_activity_conditioner #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned N_ACT           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned STRETCH_CYCLES  = 1200000
) (
  input logic                      clock,
  input logic                      rst_n,
  io_activity_conditioner_if.slave bus
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned StW = $clog2(STRETCH_CYCLES + 1);

  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [StW-1:0] StLoad = StW'(STRETCH_CYCLES);

  // Synchronisers (preset to the idle pad level so reset release is event-free)
  logic [N_BTN-1:0] btn_sync1_q, btn_sync2_q;
  logic [N_ACT-1:0] act_sync1_q, act_sync2_q;

  // Debouncer state
  logic [N_BTN-1:0] btn_s;
  logic [N_BTN-1:0] btn_q, btn_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [DbW-1:0]   db_cnt_q [N_BTN];
  logic [DbW-1:0]   db_cnt_d [N_BTN];

  // Stretcher state
  logic [N_ACT-1:0] act_prev_q;
  logic [N_ACT-1:0] act_edge;
  logic [N_ACT-1:0] led_q, led_d;
  logic [StW-1:0]   st_cnt_q [N_ACT];
  logic [StW-1:0]   st_cnt_d [N_ACT];

  assign btn_s    = ~btn_sync2_q;
  assign act_edge = act_sync2_q ^ act_prev_q;

  always_comb begin
    btn_d     = btn_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (btn_s[i] == btn_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbLast) begin
        btn_d[i]     = btn_s[i];
        db_cnt_d[i]  = '0;
        press_d[i]   = btn_s[i];
        release_d[i] = ~btn_s[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < int'(N_ACT); i++) begin
      st_cnt_d[i] = st_cnt_q[i];
      if (act_edge[i]) begin
        st_cnt_d[i] = StLoad;
      end else if (st_cnt_q[i] != '0) begin
        st_cnt_d[i] = st_cnt_q[i] - StW'(1);
      end
      // Registered from the next count so the LED lights in the same cycle as the load
      led_d[i] = (st_cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync1_q <= '1;
      btn_sync2_q <= '1;
      btn_q       <= '0;
      press_q     <= '0;
      release_q   <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      btn_sync1_q <= bus.btn_raw_i;
      btn_sync2_q <= btn_sync1_q;
      btn_q       <= btn_d;
      press_q     <= press_d;
      release_q   <= release_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      act_sync1_q <= '1;
      act_sync2_q <= '1;
      act_prev_q  <= '1;
      led_q       <= '0;
      for (int i = 0; i < int'(N_ACT); i++) begin
        st_cnt_q[i] <= '0;
      end
    end else begin
      act_sync1_q <= bus.act_i;
      act_sync2_q <= act_sync1_q;
      act_prev_q  <= act_sync2_q;
      led_q       <= led_d;
      for (int i = 0; i < int'(N_ACT); i++) begin
        st_cnt_q[i] <= st_cnt_d[i];
      end
    end
  end

  assign bus.btn_o         = btn_q;
  assign bus.btn_press_o   = press_q;
  assign bus.btn_release_o = release_q;
  assign bus.led_o         = led_q;

endmodule

// File: tb/tb_io_activity_conditioner.sv
// Scoreboard bench for io_activity_conditioner: directed scenarios followed by random
// pad activity, checked against a pad-history reference model.
module tb_io_activity_conditioner;

  localparam int unsigned N_BTN = 4;
  localparam int unsigned N_ACT = 2;
  localparam int          DEB   = 16;
  localparam int          STR   = 32;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  io_activity_conditioner_if #(.N_BTN(N_BTN), .N_ACT(N_ACT)) bus ();

  io_activity_conditioner #(
    .N_BTN          (N_BTN),
    .N_ACT          (N_ACT),
    .DEBOUNCE_CYCLES(DEB),
    .STRETCH_CYCLES (STR)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int cyc;
    int kind;  // 0 press, 1 release, 2 led rise, 3 led fall
    int idx;
  } ev_t;

  ev_t   exp_q[$];
  string kname[4] = '{"press", "release", "led_rise", "led_fall"};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit end_req   = 1'b0;
  bit wait_fail = 1'b0;

  // Reference model: outputs derived from the pad values seen at each clock edge.
  logic [N_BTN-1:0] pb1, pb2;
  logic [N_ACT-1:0] pa1, pa2, pa3;
  logic [N_BTN-1:0] m_btn;
  logic [N_ACT-1:0] m_led;
  bit               s_hist[N_BTN][$];
  int               last_edge[N_ACT];
  bit               has_edge[N_ACT];

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      if (!rst_n) begin
        pb1   = '1;
        pb2   = '1;
        pa1   = '1;
        pa2   = '1;
        pa3   = '1;
        m_btn = '0;
        m_led = '0;
        for (int i = 0; i < int'(N_BTN); i++) s_hist[i].delete();
        for (int i = 0; i < int'(N_ACT); i++) has_edge[i] = 1'b0;
      end else begin
        for (int i = 0; i < int'(N_BTN); i++) begin
          bit s;
          bit all_diff;
          s = ~pb2[i];
          s_hist[i].push_back(s);
          if (s_hist[i].size() > DEB) void'(s_hist[i].pop_front());
          all_diff = (s_hist[i].size() == DEB);
          foreach (s_hist[i][k]) if (s_hist[i][k] == m_btn[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_btn[i] = s;
            exp_q.push_back('{cyc: cyc, kind: (s ? 0 : 1), idx: i});
          end
        end
        pb2 = pb1;
        pb1 = bus.btn_raw_i;
        for (int i = 0; i < int'(N_ACT); i++) begin
          bit lit;
          if (pa2[i] != pa3[i]) begin
            last_edge[i] = cyc;
            has_edge[i]  = 1'b1;
          end
          lit = has_edge[i] && (cyc - last_edge[i] < STR);
          if (lit != m_led[i]) exp_q.push_back('{cyc: cyc, kind: (lit ? 2 : 3), idx: i});
          m_led[i] = lit;
        end
        pa3 = pa2;
        pa2 = pa1;
        pa1 = bus.act_i;
      end
    end
  end

  task automatic match_ev(input int kind, input int idx);
    int found;
    found = -1;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (exp_q[k].kind == kind && exp_q[k].idx == idx) begin
        found = k;
        break;
      end
    end
    checks++;
    if (found < 0) begin
      errors++;
      $display("FAIL %s[%0d]: seen at cycle %0d, required none", kname[kind], idx, cyc);
    end else begin
      if (exp_q[found].cyc != cyc) begin
        errors++;
        $display("FAIL %s[%0d]: seen at cycle %0d, required cycle %0d", kname[kind], idx, cyc,
                 exp_q[found].cyc);
      end
      exp_q.delete(found);
    end
  endtask

  // Monitor: samples on the falling edge and retires scoreboard entries.
  logic [N_ACT-1:0] prev_led;
  initial begin
    prev_led = '0;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        checks++;
        if (bus.btn_o != '0 || bus.btn_press_o != '0 || bus.btn_release_o != '0 ||
            bus.led_o != '0) begin
          errors++;
          $display("FAIL reset_outputs: btn=%b press=%b release=%b led=%b, required all 0",
                   bus.btn_o, bus.btn_press_o, bus.btn_release_o, bus.led_o);
        end
        exp_q.delete();
        prev_led = '0;
      end else begin
        for (int i = 0; i < int'(N_BTN); i++) begin
          if (bus.btn_press_o[i]) match_ev(0, i);
          if (bus.btn_release_o[i]) match_ev(1, i);
        end
        checks++;
        if ((bus.btn_press_o & bus.btn_release_o) != '0) begin
          errors++;
          $display("FAIL pulse_exclusive: press=%b release=%b, required disjoint",
                   bus.btn_press_o, bus.btn_release_o);
        end
        checks++;
        if (bus.btn_o !== m_btn) begin
          errors++;
          $display("FAIL btn_level: cycle %0d got %b required %b", cyc, bus.btn_o, m_btn);
        end
        for (int i = 0; i < int'(N_ACT); i++) begin
          if (bus.led_o[i] && !prev_led[i]) match_ev(2, i);
          if (!bus.led_o[i] && prev_led[i]) match_ev(3, i);
        end
        prev_led = bus.led_o;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
          if (exp_q[k].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s[%0d]: not seen, required at cycle %0d", kname[exp_q[k].kind],
                     exp_q[k].idx, exp_q[k].cyc);
            exp_q.delete(k);
          end
        end
      end
      if (end_req) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d events outstanding, required 0", exp_q.size());
        end
        checks++;
        if (wait_fail) begin
          errors++;
          $display("FAIL btn2_wait: btn_o[2] stayed 0 for 100 cycles, required 1");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  int bh[N_BTN];
  int ah[N_ACT];

  initial begin
    bus.btn_raw_i = '1;
    bus.act_i     = '1;
    rst_n         = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(100);

    // Clean press and release on button 0
    bus.btn_raw_i[0] = 1'b0;
    tick(40);
    bus.btn_raw_i[0] = 1'b1;
    tick(40);

    // Bouncing press on button 1
    bus.btn_raw_i[1] = 1'b0; tick(5);
    bus.btn_raw_i[1] = 1'b1; tick(3);
    bus.btn_raw_i[1] = 1'b0; tick(10);
    bus.btn_raw_i[1] = 1'b1; tick(3);
    bus.btn_raw_i[1] = 1'b0; tick(15);
    bus.btn_raw_i[1] = 1'b1; tick(3);
    bus.btn_raw_i[1] = 1'b0; tick(40);
    bus.btn_raw_i[1] = 1'b1; tick(40);

    // One-cycle glitch on act 0
    bus.act_i[0] = 1'b0; tick(1);
    bus.act_i[0] = 1'b1; tick(60);

    // Steady traffic on act 1
    repeat (20) begin
      bus.act_i[1] = ~bus.act_i[1];
      tick(10);
    end
    tick(60);

    // Reset while button 2 is held
    bus.btn_raw_i[2] = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.btn_o[2] && n < 100) begin
        tick(1);
        n++;
      end
      if (!bus.btn_o[2]) wait_fail = 1'b1;
    end
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(40);
    bus.btn_raw_i[2] = 1'b1;
    tick(40);

    // Random pad activity with one reset in the middle
    for (int i = 0; i < int'(N_BTN); i++) bh[i] = $urandom_range(1, 40);
    for (int i = 0; i < int'(N_ACT); i++) ah[i] = $urandom_range(1, 50);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        bh[i]--;
        if (bh[i] == 0) begin
          bus.btn_raw_i[i] = ~bus.btn_raw_i[i];
          bh[i] = $urandom_range(1, 40);
        end
      end
      for (int i = 0; i < int'(N_ACT); i++) begin
        ah[i]--;
        if (ah[i] == 0) begin
          bus.act_i[i] = ~bus.act_i[i];
          ah[i] = $urandom_range(1, 50);
        end
      end
      rst_n = (c < 1500 || c > 1501);
      tick(1);
    end
    rst_n         = 1'b1;
    bus.btn_raw_i = '1;
    bus.act_i     = '1;
    tick(100);

    end_req = 1'b1;
    tick(10);
    $display("FAIL end_timeout: monitor did not finish, required finish");
    $fatal(1);
  end

endmodule
